uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
- REQ-001: Parameter NREQ, default 4, number of requesters sharing the UART transmit FIFO.
- REQ-002: Parameter DBIT, default 8, data bits per byte, equal to the UART dbit.
- REQ-003: Parameter MAXBEATS, default 16, maximum bytes per grant before forced release.
- REQ-004: Port clk, input, 1, single clock; all logic is rising-edge.
- REQ-005: Port reset, input, 1, synchronous, active-high reset.
- REQ-006: Port req_valid, input, NREQ, per-requester byte-valid.
- REQ-007: Port req_data, input, NREQ*DBIT, packed bytes; requester i occupies bits [i*DBIT +: DBIT].
- REQ-008: Port req_last, input, NREQ, marks the final byte of requester i's packet.
- REQ-009: Port req_ready, output, NREQ, per-requester byte-accept.
- REQ-010: Port wdata, output, DBIT, byte to the UART transmit FIFO.
- REQ-011: Port wruart, output, 1, write strobe to the UART transmit FIFO.
- REQ-012: Port txfull, input, 1, UART transmit FIFO full.
- REQ-013: Port grant, output, NREQ, one-hot current owner, or all zero.
- REQ-014: Port busy, output, 1, high while any grant is held.
- REQ-015: Port trunc, output, 1, one-cycle pulse on a forced release at MAXBEATS.

Function
- REQ-016: FSM states are IDLE and XFER.
- REQ-017: In IDLE with any req_valid high, the block selects the first requester with req_valid high, searching upward from rr_ptr modulo NREQ; it registers grant and enters XFER on the next edge (grant visible 1 cycle after req_valid).
- REQ-018: In IDLE, grant, busy, req_ready and wruart are all 0.
- REQ-019: In XFER with owner g, req_ready[g] = ~txfull combinationally; all other req_ready bits are 0.
- REQ-020: Beat acceptance: wruart = req_valid[g] & ~txfull, wdata = req_data[g] (same cycle, combinational); wdata is 0 when wruart is 0.
- REQ-021: wruart is never high while txfull is high.
- REQ-022: The grant holds through req_valid[g] gaps; there is no timeout.
- REQ-023: beat_cnt has width $clog2(MAXBEATS); it clears on grant and increments per accepted beat.
- REQ-024: Release happens on an accepted beat with req_last[g]=1, or on an accepted beat when beat_cnt==MAXBEATS-1.
- REQ-025: On release, the next edge sets grant=0, rr_ptr=(g+1) mod NREQ, and state IDLE.
- REQ-026: A mandatory one-cycle IDLE bubble separates consecutive grants.
- REQ-027: trunc pulses for exactly one cycle, registered, following a MAXBEATS release where req_last[g]=0.
- REQ-028: When req_last and the MAXBEATS limit coincide, the release is normal and trunc stays 0.
- REQ-029: req_valid changes of non-owners during XFER have no effect.

Reset
- REQ-030: With reset high at a clk edge: state=IDLE, rr_ptr=0, beat_cnt=0, grant=0, busy=0, trunc=0.
- REQ-031: Outputs wruart and req_ready are 0 during reset.
- REQ-032: Reset mid-packet abandons the packet; no further bytes are written for it.
- REQ-033: The first cycle after reset deassertion is IDLE with rr_ptr=0.

Structure
- REQ-034: Shared package uart_pkg holds the FSM state enum (IDLE, XFER) and the default constants for DBIT and MAXBEATS.
- REQ-035: One sub-module, rr_pick, is combinational: inputs are the valid vector and rr_ptr; outputs are the one-hot winner and the any-valid flag.
- REQ-036: The block is instantiated in front of the uart wdata/wruart/txfull ports without changes to uart.

Verification
- REQ-037: Scenario: reset, then req_valid=4'b0001 with a 3-byte packet {0x41,0x42,0x43}, last on 0x43, txfull=0 -> grant=0001 one cycle later, wruart high for 3 consecutive cycles with wdata 0x41,0x42,0x43, then grant=0 and busy=0.
- REQ-038: Scenario: all four requesters hold 1-byte packets continuously -> grant order 0001, 0010, 0100, 1000, 0001, with one IDLE cycle between grants.
- REQ-039: Scenario: owner 2 mid-packet, txfull forced high for 5 cycles -> wruart=0 and req_ready[2]=0 for those 5 cycles; the byte is held and written on the first cycle txfull=0.
- REQ-040: Scenario: requester 1 sends 20 bytes with no last -> exactly 16 writes, trunc pulses once, rr_ptr advances to 2, and the remaining 4 bytes are sent under a later grant.
- REQ-041: Scenario: reset asserted after byte 2 of a 5-byte packet -> no wruart from the reset edge on, and grant=0 and rr_ptr=0 afterwards.
- REQ-042: Scenario: 16-byte packet with last on byte 16 -> normal release and trunc stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and default constants for the UART transmit arbiter.
//   arb_state_t      - arbiter FSM state (IDLE, XFER)
//   DBIT_DEFAULT     - data bits per byte, matches the UART dbit
//   MAXBEATS_DEFAULT - bytes allowed per grant before a forced release
package uart_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int unsigned DBIT_DEFAULT     = 8;
  localparam int unsigned MAXBEATS_DEFAULT = 16;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   valid     - per-requester valid vector
//   rr_ptr    - index where the upward search starts (wraps modulo NREQ)
//   winner    - one-hot first valid requester at or above rr_ptr, or zero
//   any_valid - high when any valid bit is set
module rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] winner,
  output logic            any_valid
);

  logic [NREQ-1:0] rot_valid;
  logic [NREQ-1:0] rot_win;
  logic            found;

  // Rotate so rr_ptr lands at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rot_valid = NREQ'({valid, valid} >> rr_ptr);
    rot_win   = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (rot_valid[i] && !found) begin
        rot_win[i] = 1'b1;
        found      = 1'b1;
      end
    end
    winner    = NREQ'(({rot_win, rot_win} << rr_ptr) >> NREQ);
    any_valid = |valid;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmit FIFO among NREQ byte-stream
// requesters with round-robin packet-level arbitration.
//   clk, reset           - rising-edge clock, synchronous active-high reset
//   req_valid/data/last  - per-requester byte stream (data packed i*DBIT +: DBIT)
//   req_ready            - per-requester byte accept (owner only, ~txfull)
//   wdata, wruart        - byte and write strobe to the UART transmit FIFO
//   txfull               - UART transmit FIFO full
//   grant                - one-hot current owner, or zero
//   busy                 - a grant is held
//   trunc                - one-cycle pulse after a forced release at MAXBEATS
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DBIT     = DBIT_DEFAULT,
  parameter int unsigned MAXBEATS = MAXBEATS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DBIT-1:0] req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  output logic [DBIT-1:0]      wdata,
  output logic                 wruart,
  input  logic                 txfull,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  output logic                 trunc
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = (MAXBEATS > 1) ? $clog2(MAXBEATS) : 1;

  arb_state_t      state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   next_ptr;
  logic [CW-1:0]   beat_cnt;
  logic [NREQ-1:0] pick;
  logic            any_valid;
  logic            owner_valid;
  logic            owner_last;
  logic [DBIT-1:0] owner_data;
  logic            in_xfer;
  logic            accept;
  logic            at_limit;
  logic            rel_now;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .valid     (req_valid),
    .rr_ptr    (rr_ptr),
    .winner    (pick),
    .any_valid (any_valid)
  );

  // Owner's stream and the pointer just past it, selected by the one-hot grant.
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    next_ptr    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        owner_valid = req_valid[i];
        owner_last  = req_last[i];
        owner_data  = req_data[i*DBIT +: DBIT];
        next_ptr    = (i == NREQ - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  // Reset gates the combinational handshake so nothing is written while held.
  always_comb begin
    in_xfer   = (state == XFER) && !reset;
    accept    = in_xfer && owner_valid && !txfull;
    at_limit  = (beat_cnt == CW'(MAXBEATS - 1));
    rel_now   = accept && (owner_last || at_limit);
    wruart    = accept;
    wdata     = accept ? owner_data : '0;
    req_ready = (in_xfer && !txfull) ? grant : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      trunc    <= 1'b0;
    end else begin
      trunc <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_valid) begin
            grant    <= pick;
            busy     <= 1'b1;
            beat_cnt <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (rel_now) begin
            grant    <= '0;
            busy     <= 1'b0;
            beat_cnt <= '0;
            rr_ptr   <= next_ptr;
            trunc    <= !owner_last;
            state    <= IDLE;
          end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        txfull = 1'b0;
  logic [3:0]  req_valid, req_last, req_ready, grant, en;
  logic [31:0] req_data;
  logic [7:0]  wdata;
  logic        wruart, busy, trunc;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [8:0]  q [4][$];
  logic [11:0] wlog [$];
  logic [3:0]  glog [$];
  int          tcount = 0;
  int          b2b = 0;
  logic [3:0]  prev_grant = 4'b0;

  // Reference model: owner, next search start and bytes written this grant.
  bit m_busy = 1'b0;
  bit m_trunc = 1'b0;
  int m_owner = 0;
  int m_ptr = 0;
  int m_cnt = 0;

  logic [3:0] e_grant, e_ready, w_idx;
  logic       e_wr;
  logic [7:0] e_data;
  logic [11:0] exp_w [24];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NREQ     (4),
    .DBIT     (8),
    .MAXBEATS (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .wdata     (wdata),
    .wruart    (wruart),
    .txfull    (txfull),
    .grant     (grant),
    .busy      (busy),
    .trunc     (trunc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input bit last);
    q[i].push_back({last, d});
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (en[i] && q[i].size() > 0) begin
        req_valid[i]         = 1'b1;
        req_data[i*8 +: 8]   = q[i][0][7:0];
        req_last[i]          = q[i][0][8];
      end else begin
        req_valid[i]         = 1'b0;
        req_data[i*8 +: 8]   = 8'h00;
        req_last[i]          = 1'b0;
      end
    end
  endtask

  task automatic step();
    logic [3:0] fire;
    @(negedge clk);
    fire = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (fire[i]) void'(q[i].pop_front());
    drive();
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) q[i].delete();
    drive();
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic clear_logs();
    wlog.delete();
    glog.delete();
    tcount = 0;
    b2b = 0;
  endtask

  // Per-cycle compare against the model, then advance the model with the
  // inputs that the coming rising edge will see.
  always @(negedge clk) begin
    e_grant = m_busy ? 4'(1 << m_owner) : 4'b0;
    e_ready = (!reset && m_busy && !txfull) ? e_grant : 4'b0;
    e_wr    = !reset && m_busy && !txfull && req_valid[m_owner];
    e_data  = e_wr ? req_data[m_owner*8 +: 8] : 8'h00;
    if (chk_en) begin
      chk("grant", {28'b0, grant}, {28'b0, e_grant});
      chk("busy", {31'b0, busy}, {31'b0, m_busy});
      chk("trunc", {31'b0, trunc}, {31'b0, m_trunc});
      chk("req_ready", {28'b0, req_ready}, {28'b0, e_ready});
      chk("wruart", {31'b0, wruart}, {31'b0, e_wr});
      chk("wdata", {24'b0, wdata}, {24'b0, e_data});
      chk("wr_while_full", {31'b0, wruart & txfull}, 32'd0);
    end
    if (wruart) begin
      w_idx = 4'd0;
      for (int i = 0; i < 4; i++) if (grant[i]) w_idx = 4'(i);
      wlog.push_back({w_idx, wdata});
    end
    if (trunc) tcount++;
    if (grant != 4'b0 && grant != prev_grant) glog.push_back(grant);
    if (prev_grant != 4'b0 && grant != 4'b0 && grant != prev_grant) b2b++;
    prev_grant = grant;

    if (reset) begin
      m_busy = 1'b0; m_trunc = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    end else if (!m_busy) begin
      m_trunc = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (!m_busy && req_valid[(m_ptr + k) % 4]) begin
          m_busy = 1'b1; m_owner = (m_ptr + k) % 4; m_cnt = 0;
        end
      end
    end else begin
      m_trunc = 1'b0;
      if (e_wr) begin
        m_cnt++;
        if (req_last[m_owner]) begin
          m_busy = 1'b0; m_ptr = (m_owner + 1) % 4;
        end else if (m_cnt == 16) begin
          m_busy = 1'b0; m_ptr = (m_owner + 1) % 4; m_trunc = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    en = 4'b1111;
    req_valid = '0; req_last = '0; req_data = '0;
    apply_reset();
    chk_en = 1'b1;
    chk("rst_grant", {28'b0, grant}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_trunc", {31'b0, trunc}, 32'd0);

    // Single 3-byte packet from requester 0.
    clear_logs();
    push(0, 8'h41, 0); push(0, 8'h42, 0); push(0, 8'h43, 1);
    drive(); #1;
    chk("s1_idle_grant", {28'b0, grant}, 32'd0);
    chk("s1_idle_wr", {31'b0, wruart}, 32'd0);
    step();
    chk("s1_grant", {28'b0, grant}, 32'h1);
    chk("s1_b0", {23'b0, wruart, wdata}, 32'h141);
    step();
    chk("s1_b1", {23'b0, wruart, wdata}, 32'h142);
    step();
    chk("s1_b2", {23'b0, wruart, wdata}, 32'h143);
    step();
    chk("s1_rel_grant", {28'b0, grant}, 32'd0);
    chk("s1_rel_busy", {31'b0, busy}, 32'd0);
    chk("s1_nwrites", wlog.size(), 32'd3);

    // Four requesters, 1-byte packets, round robin with bubbles.
    apply_reset(); clear_logs();
    for (int i = 0; i < 4; i++) begin
      push(i, 8'h20 + 8'(i), 1); push(i, 8'h30 + 8'(i), 1);
    end
    drive(); #1;
    repeat (12) step();
    chk("s2_ngrants_ge5", {31'b0, glog.size() >= 5}, 32'd1);
    if (glog.size() >= 5) begin
      chk("s2_g0", {28'b0, glog[0]}, 32'h1);
      chk("s2_g1", {28'b0, glog[1]}, 32'h2);
      chk("s2_g2", {28'b0, glog[2]}, 32'h4);
      chk("s2_g3", {28'b0, glog[3]}, 32'h8);
      chk("s2_g4", {28'b0, glog[4]}, 32'h1);
    end
    chk("s2_no_bubble_skips", b2b, 32'd0);

    // txfull stall mid-packet on requester 2.
    apply_reset(); clear_logs();
    for (int k = 0; k < 5; k++) push(2, 8'h10 + 8'(k), k == 4);
    drive(); #1;
    step();
    chk("s3_grant", {28'b0, grant}, 32'h4);
    chk("s3_b0", {24'b0, wdata}, 32'h10);
    step();
    txfull = 1'b1; #1;
    for (int k = 0; k < 5; k++) begin
      chk("s3_full_wr", {31'b0, wruart}, 32'd0);
      chk("s3_full_rdy", {31'b0, req_ready[2]}, 32'd0);
      step();
    end
    txfull = 1'b0; #1;
    chk("s3_held", {23'b0, wruart, wdata}, 32'h111);
    repeat (6) step();
    chk("s3_nwrites", wlog.size(), 32'd5);
    for (int k = 0; k < 5; k++)
      if (k < wlog.size()) chk("s3_seq", {20'b0, wlog[k]}, 32'h210 + 32'(k));

    // 20 bytes without last from requester 1: forced release at 16.
    apply_reset(); clear_logs();
    en = 4'b0010;
    for (int k = 0; k < 20; k++) push(1, 8'h60 + 8'(k), 0);
    push(3, 8'hA3, 1); push(0, 8'hA0, 1);
    drive(); #1;
    step();
    chk("s4_grant", {28'b0, grant}, 32'h2);
    en = 4'b1111; drive(); #1;
    repeat (34) step();
    chk("s4_trunc_count", tcount, 32'd1);
    chk("s4_ngrants", glog.size(), 32'd4);
    if (glog.size() == 4) begin
      chk("s4_g0", {28'b0, glog[0]}, 32'h2);
      chk("s4_g1", {28'b0, glog[1]}, 32'h8);
      chk("s4_g2", {28'b0, glog[2]}, 32'h1);
      chk("s4_g3", {28'b0, glog[3]}, 32'h2);
    end
    for (int k = 0; k < 16; k++) exp_w[k] = {4'h1, 8'h60 + 8'(k)};
    exp_w[16] = 12'h3A3;
    exp_w[17] = 12'h0A0;
    for (int k = 0; k < 4; k++) exp_w[18 + k] = {4'h1, 8'h70 + 8'(k)};
    chk("s4_nwrites", wlog.size(), 32'd22);
    for (int k = 0; k < 22; k++)
      if (k < wlog.size()) chk("s4_seq", {20'b0, wlog[k]}, {20'b0, exp_w[k]});

    // Reset in the middle of a 5-byte packet from requester 1.
    apply_reset(); clear_logs();
    push(0, 8'h50, 1);
    drive(); #1;
    repeat (3) step();
    for (int k = 1; k <= 5; k++) push(1, 8'h50 + 8'(k), k == 5);
    drive(); #1;
    step();
    chk("s5_grant", {28'b0, grant}, 32'h2);
    step();
    step();
    reset = 1'b1; #1;
    chk("s5_rst_wr", {31'b0, wruart}, 32'd0);
    chk("s5_rst_rdy", {28'b0, req_ready}, 32'd0);
    chk("s5_nwrites", wlog.size(), 32'd3);
    if (wlog.size() == 3) begin
      chk("s5_w0", {20'b0, wlog[0]}, 32'h050);
      chk("s5_w2", {20'b0, wlog[2]}, 32'h152);
    end
    apply_reset();
    chk("s5_post_grant", {28'b0, grant}, 32'd0);
    chk("s5_post_busy", {31'b0, busy}, 32'd0);
    push(0, 8'hB0, 1); push(1, 8'hB1, 1);
    drive(); #1;
    step();
    chk("s5_ptr0_grant", {28'b0, grant}, 32'h1);
    repeat (4) step();
    chk("s5_total", wlog.size(), 32'd5);
    if (wlog.size() == 5) begin
      chk("s5_w3", {20'b0, wlog[3]}, 32'h0B0);
      chk("s5_w4", {20'b0, wlog[4]}, 32'h1B1);
    end

    // 16-byte packet with last on byte 16: normal release.
    apply_reset(); clear_logs();
    for (int k = 0; k < 16; k++) push(2, 8'hC0 + 8'(k), k == 15);
    drive(); #1;
    repeat (20) step();
    chk("s6_trunc_count", tcount, 32'd0);
    chk("s6_nwrites", wlog.size(), 32'd16);
    if (wlog.size() == 16) chk("s6_last", {20'b0, wlog[15]}, 32'h2CF);
    chk("s6_grant", {28'b0, grant}, 32'd0);
    chk("s6_busy", {31'b0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
